reg_file_16x16: RTL

Sixteen-entry, 16-bit register file for the 16-bit processor datapath, built from per-entry 16-bit registers. It sits downstream of write-back, which supplies the write port, and upstream of the ALU operand muxes, which consume two combinational read ports. Register 0 is hardwired to zero. A multi-cycle clear sequencer zeroes the file one entry per cycle on command and reports `busy` while it runs.

---
 rtl/proc_pkg.sv | 17 +
 rtl/reg_file_16x16_register16bit.sv | 31 +++
 rtl/reg_file_16x16.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor datapath.
//   RF_DATA_WIDTH : default register / data-port width
//   RF_NUM_REGS   : default number of register-file entries
//   RF_ADDR_WIDTH : register-address width for the default entry count
//   rf_state_t    : register-file clear-sequencer state encoding
package proc_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_NUM_REGS   = 16;
    localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_16x16_register16bit.sv
// One register-file entry: WIDTH-bit register with load enable.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears q to zero
//   we    : load enable; d is captured on the rising edge when high
//   d     : load value
//   q     : stored value
module register16bit
    import proc_pkg::*;
#(
    parameter int WIDTH = RF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage element: load on enable, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (we) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/reg_file_16x16.sv
// Register file: NUM_REGS entries of DATA_WIDTH bits, two combinational read
// ports, one write port, entry 0 hardwired to zero, and a clear sequencer
// that zeroes entries 1..NUM_REGS-1 one per cycle.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, an accepted write
// is forwarded combinationally to any read port addressing the same entry.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   readAddrA/B  : read selects
//   dataOutA/B   : combinational read data
//   write        : write request
//   writeAddr    : write destination
//   writeData    : write value
//   clear        : start clear sequence (sampled on the clock edge)
//   busy         : clear sequence in progress (registered)
//   writeDropped : one-cycle pulse after a discarded write (registered)
module reg_file_16x16
    import proc_pkg::*;
#(
    parameter int  DATA_WIDTH = RF_DATA_WIDTH,
    parameter int  NUM_REGS   = RF_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readAddrA,
    input  logic [ADDR_WIDTH-1:0] readAddrB,
    output logic [DATA_WIDTH-1:0] dataOutA,
    output logic [DATA_WIDTH-1:0] dataOutB,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  clear,
    output logic                  busy,
    output logic                  writeDropped
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    rf_state_t               state_r;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    busy_r;
    logic                    write_dropped_r;

    logic                    in_idle_s;
    logic                    in_clear_s;
    logic                    clear_accept_s;
    logic                    wr_accept_s;
    logic                    wr_drop_s;
    logic [DATA_WIDTH-1:0]   entry_d_s;
    logic [DATA_WIDTH-1:0]   rd_a_s;
    logic [DATA_WIDTH-1:0]   rd_b_s;
    logic [DATA_WIDTH-1:0]   entries_s [NUM_REGS];

    assign in_idle_s      = (state_r == RF_IDLE);
    assign in_clear_s     = (state_r == RF_CLEAR);
    assign clear_accept_s = in_idle_s && clear;

    // A write competing with a clear start loses; address 0 is never a drop.
    assign wr_accept_s = in_idle_s && write && !clear && (writeAddr != ZERO_ADDR);
    assign wr_drop_s   = write && (writeAddr != ZERO_ADDR) && (in_clear_s || clear_accept_s);

    // Clearing is a write of zero through the same entry load path.
    always_comb begin
        entry_d_s = writeData;
        if (in_clear_s) begin
            entry_d_s = {DATA_WIDTH{1'b0}};
        end else begin
            entry_d_s = writeData;
        end
    end

    assign entries_s[0] = {DATA_WIDTH{1'b0}};

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_entry
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(g);
            logic we_s;

            assign we_s = (wr_accept_s && (writeAddr == IDX)) ||
                          (in_clear_s && (cnt_r == IDX));

            register16bit #(
                .WIDTH (DATA_WIDTH)
            ) u_entry (
                .clk   (clk),
                .reset (reset),
                .we    (we_s),
                .d     (entry_d_s),
                .q     (entries_s[g])
            );
        end
    endgenerate

    // Clear sequencer: walks cnt_r from 1 to NUM_REGS-1, no wrap, no restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= RF_IDLE;
            cnt_r           <= ZERO_ADDR;
            busy_r          <= 1'b0;
            write_dropped_r <= 1'b0;
        end else begin
            write_dropped_r <= wr_drop_s;
            case (state_r)
                RF_IDLE: begin
                    if (clear) begin
                        state_r <= RF_CLEAR;
                        cnt_r   <= ONE_ADDR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= RF_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    if (cnt_r == LAST_IDX) begin
                        state_r <= RF_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + ONE_ADDR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= RF_IDLE;
                    cnt_r   <= ZERO_ADDR;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read muxes, with optional same-cycle forwarding of an accepted write.
    always_comb begin
        rd_a_s = entries_s[readAddrA];
        rd_b_s = entries_s[readAddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept_s && (readAddrA == writeAddr)) begin
            rd_a_s = writeData;
        end else begin
            rd_a_s = entries_s[readAddrA];
        end
        if (wr_accept_s && (readAddrB == writeAddr)) begin
            rd_b_s = writeData;
        end else begin
            rd_b_s = entries_s[readAddrB];
        end
`endif
    end

    assign dataOutA     = rd_a_s;
    assign dataOutB     = rd_b_s;
    assign busy         = busy_r;
    assign writeDropped = write_dropped_r;

endmodule
